bc_write_arbiter: RTL and testbench

Round-robin write arbiter that shares the breadcrumb buffer's controller-side input port (ctrl_in_valid / ctrl_in_rdy / ctrl_in_data) between two producers: the avoidance-path breadcrumb writer (requester 0) and the PWM command writer (requester 1). Grants are burst-based with a bounded burst length, so neither producer can starve the other. The block sits between the two producers and bc_buffer. It forwards the granted producer's words with zero added latency and keeps per-requester accepted-word counters for debug.

---
 rtl/bc_write_arbiter_if.sv | 35 +++
 rtl/bc_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bc_write_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bc_write_arbiter_if.sv
// Handshake bundle shared by the two breadcrumb producers, the write arbiter
// and bc_buffer's controller-side input port.
interface bc_write_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_last;
  logic [DATA_W-1:0] req0_data;
  logic              req0_rdy;
  logic              req1_valid;
  logic              req1_last;
  logic [DATA_W-1:0] req1_data;
  logic              req1_rdy;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              buf_rdy;

  modport master (
    output req0_valid, req0_last, req0_data,
    input  req0_rdy,
    output req1_valid, req1_last, req1_data,
    input  req1_rdy,
    input  buf_valid, buf_data,
    output buf_rdy
  );

  modport slave (
    input  req0_valid, req0_last, req0_data,
    output req0_rdy,
    input  req1_valid, req1_last, req1_data,
    output req1_rdy,
    output buf_valid, buf_data,
    input  buf_rdy
  );
endinterface

// File: rtl/bc_write_arbiter.sv
// Burst-based round-robin arbiter sharing bc_buffer's controller input port
// between the avoidance breadcrumb writer (req0) and the PWM command writer (req1).
module bc_write_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  bc_write_arbiter_if.slave  bus,
  output logic [1:0]         grant_o,
  output logic [CNT_W-1:0]   cnt0_o,
  output logic [CNT_W-1:0]   cnt1_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam logic [7:0]       MAX_BURST_C = MAX_BURST[7:0];
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             last_srv_q, last_srv_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic cur_valid_s;
  logic cur_last_s;
  logic beat_s;
  logic burst_end_s;
  logic withdraw_s;

  function automatic state_e pick(input logic v0, input logic v1, input logic last_srv);
    if (v0 && v1) begin
      pick = last_srv ? GNT0 : GNT1;
    end else if (v0) begin
      pick = GNT0;
    end else if (v1) begin
      pick = GNT1;
    end else begin
      pick = IDLE;
    end
  endfunction

  // Select the granted requester's valid/last.
  always_comb begin
    cur_valid_s = 1'b0;
    cur_last_s  = 1'b0;
    case (state_q)
      GNT0: begin
        cur_valid_s = bus.req0_valid;
        cur_last_s  = bus.req0_last;
      end
      GNT1: begin
        cur_valid_s = bus.req1_valid;
        cur_last_s  = bus.req1_last;
      end
      default: begin
        cur_valid_s = 1'b0;
        cur_last_s  = 1'b0;
      end
    endcase
  end

  assign beat_s      = (state_q != IDLE) && cur_valid_s && bus.buf_rdy;
  assign burst_end_s = beat_s && (cur_last_s || ((beat_cnt_q + 8'd1) == MAX_BURST_C));
  assign withdraw_s  = ((state_q == GNT0) || (state_q == GNT1)) && !cur_valid_s;

  // State, priority pointer, burst and debug counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_srv_q <= 1'b1;
      beat_cnt_q <= 8'd0;
      cnt0_q     <= {CNT_W{1'b0}};
      cnt1_q     <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      beat_cnt_q <= beat_cnt_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  // Next-state: grant hand-off at burst end or withdrawal, beat counting otherwise.
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        state_d    = pick(bus.req0_valid, bus.req1_valid, last_srv_q);
        beat_cnt_d = 8'd0;
      end
      GNT0: begin
        if (burst_end_s || withdraw_s) begin
          last_srv_d = 1'b0;
          beat_cnt_d = 8'd0;
          if (bus.req1_valid) begin
            state_d = GNT1;
          end else if (burst_end_s) begin
            state_d = GNT0;
          end else begin
            state_d = IDLE;
          end
        end else if (beat_s) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      GNT1: begin
        if (burst_end_s || withdraw_s) begin
          last_srv_d = 1'b1;
          beat_cnt_d = 8'd0;
          if (bus.req0_valid) begin
            state_d = GNT0;
          end else if (burst_end_s) begin
            state_d = GNT1;
          end else begin
            state_d = IDLE;
          end
        end else if (beat_s) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        last_srv_d = 1'b1;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // Per-requester accepted-word counters, wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (beat_s && (state_q == GNT0)) begin
      cnt0_d = cnt0_q + CNT_ONE;
    end else if (beat_s && (state_q == GNT1)) begin
      cnt1_d = cnt1_q + CNT_ONE;
    end else begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
    end
  end

  // Zero-latency data path steered by the grant; buf_rdy only reaches the rdy lines.
  always_comb begin
    bus.buf_valid = 1'b0;
    bus.buf_data  = {DATA_W{1'b0}};
    bus.req0_rdy  = 1'b0;
    bus.req1_rdy  = 1'b0;
    case (state_q)
      GNT0: begin
        bus.buf_valid = bus.req0_valid;
        bus.buf_data  = bus.req0_data;
        bus.req0_rdy  = bus.buf_rdy;
      end
      GNT1: begin
        bus.buf_valid = bus.req1_valid;
        bus.buf_data  = bus.req1_data;
        bus.req1_rdy  = bus.buf_rdy;
      end
      default: begin
        bus.buf_valid = 1'b0;
        bus.buf_data  = {DATA_W{1'b0}};
        bus.req0_rdy  = 1'b0;
        bus.req1_rdy  = 1'b0;
      end
    endcase
  end

  assign grant_o = state_q;
  assign cnt0_o  = cnt0_q;
  assign cnt1_o  = cnt1_q;

endmodule

// File: tb/tb_bc_write_arbiter.sv
// Directed bench for bc_write_arbiter: a default instance plus a 4-bit counter
// instance used for the wrap case.
module tb_bc_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bc_write_arbiter_if #(.DATA_W(16)) bus   ();
  bc_write_arbiter_if #(.DATA_W(16)) bus_w ();

  logic [1:0]  grant;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  grant_w;
  logic [3:0]  cnt0_w, cnt1_w;

  bc_write_arbiter #(.DATA_W(16), .MAX_BURST(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_o(grant), .cnt0_o(cnt0), .cnt1_o(cnt1)
  );

  bc_write_arbiter #(.DATA_W(16), .MAX_BURST(8), .CNT_W(4)) u_dut_w (
    .clk(clk), .rst(rst), .bus(bus_w),
    .grant_o(grant_w), .cnt0_o(cnt0_w), .cnt1_o(cnt1_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req0_valid   = 1'b0; bus.req0_last   = 1'b0; bus.req0_data   = 16'h0000;
    bus.req1_valid   = 1'b0; bus.req1_last   = 1'b0; bus.req1_data   = 16'h0000;
    bus.buf_rdy      = 1'b1;
    bus_w.req0_valid = 1'b0; bus_w.req0_last = 1'b0; bus_w.req0_data = 16'h0000;
    bus_w.req1_valid = 1'b0; bus_w.req1_last = 1'b0; bus_w.req1_data = 16'h0000;
    bus_w.buf_rdy    = 1'b1;
  endtask

  // Reset spans one rising edge and releases 1 time unit after it.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  logic [1:0] exp_g;

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.buf_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_valid", bus.buf_valid, 1'b0);
    chk("rst_data",  bus.buf_data, 16'h0000);
    chk("rst_rdy0",  bus.req0_rdy, 1'b0);
    chk("rst_rdy1",  bus.req1_rdy, 1'b0);
    chk("rst_cnt0",  cnt0, 16'd0);
    chk("rst_cnt1",  cnt1, 16'd0);

    // Single 3-word burst from req0.
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 16'hA001; bus.buf_rdy = 1'b1;
    @(negedge clk);
    chk("single_idle",  grant, 2'b00);
    chk("single_noacc", bus.req0_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.req0_data = 16'hA001 + 16'(i);
      bus.req0_last = (i == 2);
      @(negedge clk);
      chk("single_grant", grant, 2'b01);
      chk("single_valid", bus.buf_valid, 1'b1);
      chk("single_data",  bus.buf_data, 32'hA001 + 32'(i));
      chk("single_rdy",   bus.req0_rdy, 1'b1);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
    @(negedge clk);
    chk("single_cnt0", cnt0, 16'd3);
    chk("single_gap",  bus.buf_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("single_release", grant, 2'b00);

    // Contention: alternating 8-beat bursts, req0 first, no gaps.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 16'hB000;
    bus.req1_valid = 1'b1; bus.req1_data = 16'hC000;
    @(negedge clk);
    chk("cont_idle", grant, 2'b00);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_g = (((k / 8) % 2) == 0) ? 2'b01 : 2'b10;
      chk("cont_grant", grant, exp_g);
      chk("cont_valid", bus.buf_valid, 1'b1);
      chk("cont_data",  bus.buf_data, (exp_g == 2'b01) ? 32'hB000 : 32'hC000);
    end
    @(posedge clk);
    @(negedge clk);
    chk("cont_cnt0",  cnt0, 16'd16);
    chk("cont_cnt1",  cnt1, 16'd16);
    chk("cont_wrapg", grant, 2'b01);

    // Back-pressure: stall GNT1 after 3 beats for 5 cycles.
    repeat (8) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    bus.buf_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_grant", grant, 2'b10);
      chk("bp_rdy1",  bus.req1_rdy, 1'b0);
      chk("bp_data",  bus.buf_data, 16'hC000);
      chk("bp_cnt1",  cnt1, 16'd19);
      @(posedge clk);
    end
    #1;
    bus.buf_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resume", grant, 2'b10);
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_switch", grant, 2'b01);
    chk("bp_cnt1e",  cnt1, 16'd24);
    chk("bp_cnt0e",  cnt0, 16'd24);

    // Withdrawal of req0 after 2 beats.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 16'hB000;
    bus.req1_valid = 1'b1; bus.req1_data = 16'hC000;
    repeat (3) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("wd_hold", grant, 2'b01);
    chk("wd_gap",  bus.buf_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("wd_grant", grant, 2'b10);
    chk("wd_valid", bus.buf_valid, 1'b1);
    chk("wd_data",  bus.buf_data, 16'hC000);
    chk("wd_cnt0",  cnt0, 16'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("wd_nogap", bus.buf_valid, 1'b1);
    end

    // Counter wrap on the 4-bit instance.
    do_reset();
    bus_w.req1_valid = 1'b1; bus_w.req1_data = 16'hD000;
    @(posedge clk); #1;
    chk("wrap_grant", grant_w, 2'b10);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 16) chk("wrap_zero", cnt1_w, 4'd0);
    end
    chk("wrap_cnt1",  cnt1_w, 4'd1);
    chk("wrap_keepg", grant_w, 2'b10);
    bus_w.req1_valid = 1'b0;

    // Asynchronous reset in the middle of a GNT0 burst.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 16'hE000;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_pre_grant", grant, 2'b01);
    chk("mid_pre_cnt0",  cnt0, 16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_grant", grant, 2'b00);
    chk("mid_valid", bus.buf_valid, 1'b0);
    chk("mid_data",  bus.buf_data, 16'h0000);
    chk("mid_rdy0",  bus.req0_rdy, 1'b0);
    chk("mid_cnt0",  cnt0, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 16'hF000;
    @(posedge clk); #1;
    chk("mid_first", grant, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
